// File: rtl/com_op_code_sequencer.sv
// Firmware op-code sequencer: accepts one command at a time, pulses the op strobe,
// and for w_execute starts one test state machine and waits for its done edge.
//
// state     | meaning
// IDLE      | ready for a command
// ISSUE     | op pulse is high; decide between returning and starting a test
// START     | sm_test_start is high for the selected test
// WAIT_DONE | counting cycles until the selected done bit rises or time runs out
module com_op_code_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op_code,
  input  logic [3:0]  cmd_test_sel,
  input  logic        abort,
  input  logic [3:0]  sm_test_done,
  output logic [14:0] op_code_pulse,
  output logic [3:0]  sm_test_start,
  output logic        busy,
  output logic        error_w_execute_cfg,
  output logic        error_illegal_op,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, START, WAIT_DONE} state_t;

  localparam logic [3:0] OP_STATUS_CLEAR = 4'd0;
  localparam logic [3:0] OP_EXECUTE      = 4'd14;
  localparam logic [3:0] OP_ILLEGAL      = 4'd15;

  state_t      state;
  logic [3:0]  op_q;
  logic [3:0]  sel_q;
  logic        sel_ok_q;
  logic [3:0]  done_prev;
  logic [31:0] count;

  logic        sel_one_hot;
  logic        done_seen;

  assign sel_one_hot = (cmd_test_sel != 4'd0) &&
                       ((cmd_test_sel & (cmd_test_sel - 4'd1)) == 4'd0);
  // Only a 0->1 transition on the selected bit counts; a level already high does not.
  assign done_seen   = |(sm_test_done & ~done_prev & sel_q);

  always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
    if (fw_rst) begin
      state               <= IDLE;
      op_q                <= '0;
      sel_q               <= '0;
      sel_ok_q            <= 1'b0;
      done_prev           <= 4'b1111;
      count               <= '0;
      cmd_ready           <= 1'b1;
      busy                <= 1'b0;
      op_code_pulse       <= '0;
      sm_test_start       <= '0;
      error_w_execute_cfg <= 1'b0;
      error_illegal_op    <= 1'b0;
      timeout             <= 1'b0;
    end else begin
      done_prev     <= sm_test_done;
      op_code_pulse <= '0;
      sm_test_start <= '0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= ISSUE;
            op_q      <= cmd_op_code;
            sel_q     <= cmd_test_sel;
            sel_ok_q  <= sel_one_hot;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_op_code != OP_ILLEGAL)
              op_code_pulse <= 15'd1 << cmd_op_code;
            if (cmd_op_code == OP_STATUS_CLEAR) begin
              error_w_execute_cfg <= 1'b0;
              error_illegal_op    <= 1'b0;
              timeout             <= 1'b0;
            end
          end
        end

        ISSUE: begin
          if (!abort && op_q == OP_EXECUTE && sel_ok_q) begin
            state         <= START;
            sm_test_start <= sel_q;
          end else begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            if (!abort && op_q == OP_ILLEGAL)
              error_illegal_op <= 1'b1;
            if (!abort && op_q == OP_EXECUTE)
              error_w_execute_cfg <= 1'b1;
          end
        end

        START: begin
          count <= '0;
          if (abort) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (abort || done_seen) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            count     <= '0;
          end else if (count == TIMEOUT_CYCLES - 32'd1) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            count     <= '0;
            timeout   <= 1'b1;
          end else begin
            count <= count + 32'd1;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          count     <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/com_op_code_sequencer.md
COM_OP_CODE_SEQUENCER -- requirements
Module: com_op_code_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the maximum WAIT_DONE cycles before timeout (legal range 2..2^32-1).
REQ-002 SHALL have port fw_axi_clk  in  1  FW clock 100 MHz; sole clock.
REQ-003 SHALL have port fw_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  in  1  command strobe.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-006 SHALL have port cmd_op_code  in  4  op code (table in REQ-012).
REQ-007 SHALL have port cmd_test_sel  in  4  test select for execute; bit i = test i+1.
REQ-008 SHALL have port abort  in  1  single-cycle abort request.
REQ-009 SHALL have port sm_test_done  in  4  bit i = sm_test{i+1}_o_status_done level.
REQ-010 SHALL have ports op_code_pulse  out  15 (one-hot op pulse, bit = op code), sm_test_start  out  4, busy  out  1, error_w_execute_cfg  out  1, error_illegal_op  out  1, timeout  out  1.

Function
REQ-011 All outputs SHALL be registered; FSM states: IDLE, ISSUE, START, WAIT_DONE.
REQ-012 Op codes SHALL be: 0 w_status_clear, 1 w_reset, 2/3 w/r_cfg_static_0, 4/5 w/r_cfg_static_1, 6/7 w/r_cfg_array_0, 8/9 w/r_cfg_array_1, 10/11 w/r_cfg_array_2, 12/13 r_data_array_0/1, 14 w_execute, 15 illegal.
REQ-013 cmd_ready SHALL be 1 only in IDLE, independent of cmd_valid; busy SHALL be ~cmd_ready.
REQ-014 On acceptance at edge N, op code and test select SHALL be captured and FSM SHALL enter ISSUE; op_code_pulse[op] SHALL be high for exactly the cycle after edge N.
REQ-015 Op codes 0..13: ISSUE SHALL return to IDLE at the next edge (cmd_ready high again cycle N+2).
REQ-016 Op code 0 SHALL additionally clear error_w_execute_cfg, error_illegal_op and timeout at the same edge its pulse asserts.
REQ-017 Op code 15 SHALL produce no pulse, SHALL set sticky error_illegal_op, and SHALL return IDLE via ISSUE.
REQ-018 Op code 14 with cmd_test_sel not exactly one-hot SHALL pulse bit 14, set sticky error_w_execute_cfg, and return IDLE without starting any test.
REQ-019 Op code 14 with one-hot cmd_test_sel SHALL pulse bit 14, then enter START: sm_test_start = captured select for exactly one cycle (cycle N+2), then enter WAIT_DONE.
REQ-020 WAIT_DONE SHALL detect completion on a rising edge (0->1 between consecutive samples) of the selected sm_test_done bit only; a level already high, or other bits, SHALL be ignored.
REQ-021 WAIT_DONE SHALL count cycles from 0 at entry (32-bit, no wrap); at count TIMEOUT_CYCLES-1 without completion it SHALL set sticky timeout and return IDLE.
REQ-022 Completion and timeout on the same cycle SHALL be treated as completion (timeout not set).
REQ-023 abort high in any non-IDLE state SHALL return FSM to IDLE at the next edge, cancelling pending pulse/start, clearing counter, setting no flag; abort in IDLE SHALL be ignored; abort has priority over completion and timeout.
REQ-024 Sticky flags SHALL otherwise hold until op code 0 or reset.

Reset
REQ-025 fw_rst high SHALL asynchronously force IDLE, counter 0, op_code_pulse 0, sm_test_start 0, all flags 0, busy 0, cmd_ready 1 after deassertion edge; reset mid-WAIT_DONE SHALL abandon the test silently.
REQ-026 Done-edge history register SHALL reset to 4'b1111 so a done held high through reset is not a completion.

Verification (TIMEOUT_CYCLES=16)
REQ-027 Accept op 6 at edge N -> op_code_pulse=15'h0040 for one cycle N+1, cmd_ready=1 at N+2, no flags.
REQ-028 Op 14, sel 4'b0100, sm_test_done[2] rises 5 cycles after start -> sm_test_start=4'b0100 one cycle, busy drops the cycle after the edge, timeout=0.
REQ-029 Op 14, sel 4'b0110 -> pulse bit 14, no start, error_w_execute_cfg=1; then op 0 -> flag 0.
REQ-030 Op 14, sel 4'b0001, done never rises -> timeout=1 after 16 WAIT_DONE cycles, IDLE; done[0] held high from before start also yields timeout.
REQ-031 Op 14 then abort during WAIT_DONE, and fw_rst asserted mid-WAIT_DONE -> IDLE, no flags, counter 0.
REQ-032 Op 15 -> no pulse, error_illegal_op=1, cmd_ready=1 at N+2.
